// File: rtl/hood_mode_fsm.sv
// hood_mode_fsm: main mode controller for the range hood.
// Tracks the hood state, timed-state countdowns, the third-level usage
// latch and the power long-press off. The optional clean reminder work
// counter is built only when HOOD_CLEAN_REMINDER_EN is defined; otherwise
// clean_reminder is tied low.
module hood_mode_fsm #(
  parameter int THIRD_SEC        = 60,
  parameter int WAIT_SEC         = 60,
  parameter int CLEAN_SEC        = 180,
  parameter int POWER_HOLD_SEC   = 3,
  parameter int CNT_W            = 8,
  parameter int CLEAN_REMIND_SEC = 36000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1s,
  input  logic             power_btn,
  input  logic             menu_p,
  input  logic             level1_p,
  input  logic             level2_p,
  input  logic             level3_p,
  input  logic             clean_p,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] countdown_sec,
  output logic             third_used,
  output logic             clean_reminder
);

  localparam int HOLD_W = (POWER_HOLD_SEC < 2) ? 1 : $clog2(POWER_HOLD_SEC + 1);

  typedef enum logic [2:0] {
    S_OFF      = 3'b000,
    S_STANDBY  = 3'b001,
    S_MODE_SEL = 3'b010,
    S_FIRST    = 3'b011,
    S_SECOND   = 3'b100,
    S_THIRD    = 3'b101,
    S_CLEAN    = 3'b110,
    S_WAIT     = 3'b111
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              third_q, third_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pwr_prev_q;

  logic power_rise;
  logic timed;
  logic expire;
  logic hold_fire;

  assign power_rise = power_btn & ~pwr_prev_q;
  assign timed      = (state_q == S_THIRD) || (state_q == S_WAIT) || (state_q == S_CLEAN);
  assign expire     = timed && tick_1s && (cnt_q == CNT_W'(1));
  // The hold that completes on this tick turns the hood off this edge.
  assign hold_fire  = (state_q != S_OFF) && power_btn && tick_1s &&
                      (hold_q == HOLD_W'(POWER_HOLD_SEC - 1));

  // Next-state, countdown, hold counter and third-level latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    third_d = third_q;
    hold_d  = hold_q;

    if (state_q == S_OFF) begin
      hold_d = '0;
      if (power_rise) state_d = S_STANDBY;
    end else begin
      if (!power_btn)   hold_d = '0;
      else if (tick_1s) hold_d = hold_q + 1'b1;

      if (timed && tick_1s && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;

      if (hold_fire) begin
        state_d = S_OFF;
        hold_d  = '0;
        third_d = 1'b0;
      end else if (expire) begin
        state_d = (state_q == S_THIRD) ? S_SECOND : S_STANDBY;
      end else begin
        // First pulse in priority order that is meaningful here wins.
        case (state_q)
          S_STANDBY: begin
            if (menu_p)       state_d = S_MODE_SEL;
            else if (clean_p) state_d = S_CLEAN;
          end
          S_MODE_SEL: begin
            if (menu_p)                     state_d = S_STANDBY;
            else if (clean_p)               state_d = S_CLEAN;
            else if (level3_p && !third_q)  state_d = S_THIRD;
            else if (level2_p)              state_d = S_SECOND;
            else if (level1_p)              state_d = S_FIRST;
          end
          S_FIRST: begin
            if (menu_p)        state_d = S_STANDBY;
            else if (level2_p) state_d = S_SECOND;
          end
          S_SECOND: begin
            if (menu_p)        state_d = S_STANDBY;
            else if (level1_p) state_d = S_FIRST;
          end
          S_THIRD: begin
            if (menu_p) state_d = S_WAIT;
          end
          default: ;
        endcase
      end
    end

    // Entering a state loads its duration; untimed states hold zero.
    // A load on entry overrides any decrement from a coincident tick.
    if (state_d != state_q) begin
      case (state_d)
        S_THIRD: begin
          cnt_d   = CNT_W'(THIRD_SEC);
          third_d = 1'b1;
        end
        S_WAIT:  cnt_d = CNT_W'(WAIT_SEC);
        S_CLEAN: cnt_d = CNT_W'(CLEAN_SEC);
        default: cnt_d = '0;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      third_q    <= 1'b0;
      hold_q     <= '0;
      pwr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      third_q    <= third_d;
      hold_q     <= hold_d;
      pwr_prev_q <= power_btn;
    end
  end

  assign state         = state_q;
  assign countdown_sec = cnt_q;
  assign third_used    = third_q;

`ifdef HOOD_CLEAN_REMINDER_EN
  logic [15:0] work_q, work_d;
  logic        remind_q, remind_d;
  logic        clean_done;
  logic        working;

  assign clean_done = expire && (state_q == S_CLEAN) && !hold_fire;
  assign working    = (state_q == S_FIRST) || (state_q == S_SECOND) || (state_q == S_THIRD);

  // Saturating work-time counter; a finished self-clean restarts it.
  always_comb begin
    work_d = work_q;
    if (clean_done)
      work_d = '0;
    else if (tick_1s && working && (work_q != 16'(CLEAN_REMIND_SEC)))
      work_d = work_q + 1'b1;
    remind_d = (work_d == 16'(CLEAN_REMIND_SEC));
  end

  // Work counter and reminder flag registers; power-off keeps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      remind_q <= 1'b0;
    end else begin
      work_q   <= work_d;
      remind_q <= remind_d;
    end
  end

  assign clean_reminder = remind_q;
`else
  assign clean_reminder = 1'b0;
`endif

endmodule

// File: tb/tb_hood_mode_fsm.sv
// tb_hood_mode_fsm: directed and randomized check of hood_mode_fsm against
// a table-driven behavioural model of the hood's mode rules.
module tb_hood_mode_fsm;

  localparam int THIRD = 5;
  localparam int WAITS = 4;
  localparam int CLEAN = 3;
  localparam int HOLD  = 3;
  localparam int REM   = 6;

  localparam int OFF = 0, STBY = 1, MSEL = 2, LV1 = 3, LV2 = 4, LV3 = 5, CLN = 6, WT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1s = 1'b0, power_btn = 1'b0;
  logic       menu_p = 1'b0, level1_p = 1'b0, level2_p = 1'b0, level3_p = 1'b0, clean_p = 1'b0;
  logic [2:0] state;
  logic [7:0] countdown_sec;
  logic       third_used, clean_reminder;

  int vectors = 0;
  int errs    = 0;

  // model state
  int m_st, m_cnt, m_third, m_hold, m_prev, m_work;
  int tab [8][5];   // [state][button: 0 menu,1 clean,2 l3,3 l2,4 l1] -> next state or -1

  hood_mode_fsm #(
    .THIRD_SEC(THIRD), .WAIT_SEC(WAITS), .CLEAN_SEC(CLEAN),
    .POWER_HOLD_SEC(HOLD), .CNT_W(8), .CLEAN_REMIND_SEC(REM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .power_btn(power_btn),
    .menu_p(menu_p), .level1_p(level1_p), .level2_p(level2_p), .level3_p(level3_p),
    .clean_p(clean_p), .state(state), .countdown_sec(countdown_sec),
    .third_used(third_used), .clean_reminder(clean_reminder)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int s);
    if (s == LV3) return THIRD;
    if (s == WT)  return WAITS;
    if (s == CLN) return CLEAN;
    return 0;
  endfunction

  function automatic void model_reset();
    m_st = OFF; m_cnt = 0; m_third = 0; m_hold = 0; m_prev = 0; m_work = 0;
  endfunction

  // One clock of hood behaviour, written from the mode rules.
  function automatic void model_step(input bit t, input bit p, input bit [4:0] b);
    int old;
    bit rise;
    bit timed;
    old   = m_st;
    rise  = p && (m_prev == 0);
    m_prev = p;
    timed = (dur(m_st) != 0);
    if (t && (m_st == LV1 || m_st == LV2 || m_st == LV3) && m_work < REM) m_work++;
    if (m_st == OFF) begin
      m_hold = 0;
      if (rise) m_st = STBY;
      return;
    end
    m_hold = p ? m_hold + int'(t) : 0;
    if (m_hold == HOLD) begin
      m_st = OFF; m_hold = 0; m_cnt = 0; m_third = 0;
      return;
    end
    if (timed && t && m_cnt == 1) begin
      if (old == CLN) m_work = 0;
      m_st  = (old == LV3) ? LV2 : STBY;
      m_cnt = 0;
      return;
    end
    for (int k = 0; k < 5; k++) begin
      if (b[4-k] && tab[m_st][k] >= 0 && !(tab[m_st][k] == LV3 && m_third != 0)) begin
        m_st = tab[m_st][k];
        break;
      end
    end
    if (m_st != old) begin
      m_cnt = dur(m_st);
      if (m_st == LV3) m_third = 1;
    end else if (timed && t && m_cnt > 0) begin
      m_cnt--;
    end
  endfunction

  function automatic bit m_rem();
`ifdef HOOD_CLEAN_REMINDER_EN
    return (m_work == REM);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    logic [2:0] es;
    logic [7:0] ec;
    es = m_st[2:0];
    ec = m_cnt[7:0];
    vectors++;
    assert (state === es) else begin
      errs++; $error("FAIL %s state: got %b want %b", tag, state, es);
    end
    assert (countdown_sec === ec) else begin
      errs++; $error("FAIL %s countdown: got %0d want %0d", tag, countdown_sec, ec);
    end
    assert (third_used === m_third[0]) else begin
      errs++; $error("FAIL %s third_used: got %b want %b", tag, third_used, m_third[0]);
    end
    assert (clean_reminder === m_rem()) else begin
      errs++; $error("FAIL %s clean_reminder: got %b want %b", tag, clean_reminder, m_rem());
    end
  endtask

  task automatic expect_st(input string tag, input logic [2:0] e);
    assert (state === e) else begin
      errs++; $error("FAIL %s plan-state: got %b want %b", tag, state, e);
    end
  endtask

  // Drive one cycle of inputs, advance the clock, compare with the model.
  task automatic step(input string tag, input bit t, input bit p, input bit [4:0] b);
    tick_1s = t; power_btn = p;
    menu_p = b[4]; clean_p = b[3]; level3_p = b[2]; level2_p = b[1]; level1_p = b[0];
    model_step(t, p, b);
    @(posedge clk); #1;
    check_all(tag);
    $display("step %-10s tick=%b pwr=%b btn=%b -> state=%b cnt=%0d third=%b rem=%b",
             tag, t, p, b, state, countdown_sec, third_used, clean_reminder);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_1s = 0; power_btn = 0; menu_p = 0; clean_p = 0; level1_p = 0; level2_p = 0; level3_p = 0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all("reset_rel");
  endtask

  localparam bit [4:0] B_MENU = 5'b10000, B_CLEAN = 5'b01000, B_L3 = 5'b00100,
                       B_L2 = 5'b00010, B_L1 = 5'b00001, B_NONE = 5'b00000;

  initial begin
    bit p;
    bit [4:0] b;
    for (int s = 0; s < 8; s++)
      for (int k = 0; k < 5; k++) tab[s][k] = -1;
    tab[STBY][0] = MSEL; tab[STBY][1] = CLN;
    tab[MSEL][0] = STBY; tab[MSEL][1] = CLN; tab[MSEL][2] = LV3; tab[MSEL][3] = LV2; tab[MSEL][4] = LV1;
    tab[LV1][0]  = STBY; tab[LV1][3]  = LV2;
    tab[LV2][0]  = STBY; tab[LV2][4]  = LV1;
    tab[LV3][0]  = WT;

    @(posedge clk); #1;
    do_reset();

    // Power sequence
    step("pwr_on", 0, 1, B_NONE);          expect_st("pwr_on", 3'b001);
    for (int i = 0; i < 3; i++) step("hold", 1, 1, B_NONE);
    expect_st("hold_off", 3'b000);
    for (int i = 0; i < 5; i++) step("held", 1, 1, B_NONE);
    expect_st("held_off", 3'b000);
    step("release", 0, 0, B_NONE);
    step("pwr_on2", 0, 1, B_NONE);         expect_st("pwr_on2", 3'b001);
    step("release2", 0, 0, B_NONE);

    // Levels, and work time in FIRST_LEVEL
    step("menu", 0, 0, B_MENU);            expect_st("menu", 3'b010);
    step("lvl2", 0, 0, B_L2);              expect_st("lvl2", 3'b100);
    step("lvl1", 0, 0, B_L1);              expect_st("lvl1", 3'b011);
    for (int i = 0; i < 6; i++) step("work", 1, 0, B_NONE);
`ifdef HOOD_CLEAN_REMINDER_EN
    assert (clean_reminder === 1'b1) else begin
      errs++; $error("FAIL remind_on: got %b want 1", clean_reminder);
    end
`endif
    step("menu_sb", 0, 0, B_MENU);         expect_st("menu_sb", 3'b001);

    // Third level
    step("menu", 0, 0, B_MENU);
    step("lvl3", 0, 0, B_L3);              expect_st("lvl3", 3'b101);
    for (int i = 0; i < 5; i++) step("t3", 1, 0, B_NONE);
    expect_st("t3_exp", 3'b100);
    step("menu", 0, 0, B_MENU);
    step("menu", 0, 0, B_MENU);
    step("lvl3_used", 0, 0, B_L3);         expect_st("lvl3_used", 3'b010);

    // Power-cycle to re-arm third level, then wait-to-standby
    for (int i = 0; i < 3; i++) step("hold", 1, 1, B_NONE);
    step("release", 0, 0, B_NONE);
    step("pwr_on", 0, 1, B_NONE);
    step("release", 0, 0, B_NONE);
    step("menu", 0, 0, B_MENU);
    step("lvl3", 0, 0, B_L3);
    step("to_wait", 0, 0, B_MENU);         expect_st("to_wait", 3'b111);
    step("wait_l1", 0, 0, B_L1);           expect_st("wait_l1", 3'b111);
    for (int i = 0; i < 4; i++) step("wt", 1, 0, B_NONE);
    expect_st("wait_exp", 3'b001);

    // Priority and simultaneity
    step("menu", 0, 0, B_MENU);
    step("multi", 0, 0, B_MENU | B_CLEAN | B_L3); expect_st("multi", 3'b001);
    step("clean", 0, 0, B_CLEAN);          expect_st("clean", 3'b110);
    step("ch1", 1, 1, B_NONE);
    step("ch2", 1, 1, B_NONE);
    step("hold_exp", 1, 1, B_NONE);        expect_st("hold_exp", 3'b000);
    step("release", 0, 0, B_NONE);

    // Self-clean completion
    step("pwr_on", 0, 1, B_NONE);
    step("release", 0, 0, B_NONE);
    step("clean", 0, 0, B_CLEAN);
    for (int i = 0; i < 3; i++) step("cln", 1, 0, B_NONE);
    expect_st("cln_exp", 3'b001);
    assert (clean_reminder === 1'b0) else begin
      errs++; $error("FAIL remind_clr: got %b want 0", clean_reminder);
    end

    // Randomized traffic with occasional reset
    p = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        p = 0;
      end else begin
        if ($urandom_range(0, 19) == 0) p = ~p;
        b = B_NONE;
        if ($urandom_range(0, 3) == 0) b = 5'b00001 << $urandom_range(0, 4);
        step("rand", ($urandom_range(0, 2) == 0), p, b);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
